// File: rtl/mbus_def_pkg.sv
// ---------------------------------------------------------------------------
// mbus_def_pkg
// Shared constants for the MBus transmit arbiter slice.
//   NUM_REQ        : number of requesters sharing the node transmit port
//   ADDR_W/DATA_W  : mirrors of the existing `ADDR_WIDTH / `DATA_WIDTH macros
//   TMO_W          : width of the per-phase handshake timeout counter
//   arb_state_t    : arbiter FSM states
//   ST_SUCC/ST_FAIL/ST_TMO : completion status codes returned on R_STATUS
// ---------------------------------------------------------------------------
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package mbus_def_pkg;

    localparam int NUM_REQ = 2;
    localparam int ADDR_W  = `ADDR_WIDTH;
    localparam int DATA_W  = `DATA_WIDTH;
    localparam int TMO_W   = 20;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_SEND   = 3'd2,
        S_ACKLOW = 3'd3,
        S_RESP   = 3'd4,
        S_RACK   = 3'd5
    } arb_state_t;

    localparam logic [1:0] ST_SUCC = 2'b01;
    localparam logic [1:0] ST_FAIL = 2'b10;
    localparam logic [1:0] ST_TMO  = 2'b11;

endpackage

// File: rtl/mbus_rr_pick2.sv
// ---------------------------------------------------------------------------
// mbus_rr_pick2
// Combinational two-way round-robin picker. The pointer register lives in
// the parent so the grant only moves when a message completes.
//   i_req   : request vector
//   i_ptr   : requester favoured when both request (the one not served last)
//   o_grant : one-hot winner, 0 when nobody requests
//   o_idx   : index of the winner (meaningful only when o_grant != 0)
// ---------------------------------------------------------------------------
module mbus_rr_pick2 (
    input  logic [1:0] i_req,
    input  logic       i_ptr,
    output logic [1:0] o_grant,
    output logic       o_idx
);

    always_comb begin
        o_idx = 1'b0;
        if (i_req == 2'b11) begin
            o_idx = i_ptr;
        end else if (i_req[1]) begin
            o_idx = 1'b1;
        end
        o_grant = (i_req == 2'b00) ? 2'b00 : (o_idx ? 2'b10 : 2'b01);
    end

endmodule

// File: rtl/mbus_tx_arbiter.sv
// ---------------------------------------------------------------------------
// mbus_tx_arbiter
// Shares the single MBus node transmit port between the ICE host command
// path (requester 0) and the event generator (requester 1). A grant is held
// for a whole message; each word goes through the node's REQ/ACK four-phase
// handshake, followed by the SUCC/FAIL response handshake.
//   CLK_EXT, RESETn            : clock, asynchronous active-low reset
//   R_VALID/R_ADDR/R_DATA/R_LAST/R_PRIO : per-requester word interface
//   R_READY                    : 1-cycle pulse, word consumed by the node
//   R_DONE/R_STATUS            : 1-cycle completion pulse + held status
//   GRANT                      : one-hot current owner, 0 when idle
//   TX_*                       : node transmit port (TX_ACK pre-synchronised)
// ---------------------------------------------------------------------------
module mbus_tx_arbiter
    import mbus_def_pkg::*;
#(
    parameter logic [TMO_W-1:0] ACK_TIMEOUT = 20'hFFFFF
) (
    input  logic                         CLK_EXT,
    input  logic                         RESETn,
    input  logic [NUM_REQ-1:0]           R_VALID,
    input  logic [2*`ADDR_WIDTH-1:0]     R_ADDR,
    input  logic [2*`DATA_WIDTH-1:0]     R_DATA,
    input  logic [NUM_REQ-1:0]           R_LAST,
    input  logic [NUM_REQ-1:0]           R_PRIO,
    output logic [NUM_REQ-1:0]           R_READY,
    output logic [NUM_REQ-1:0]           R_DONE,
    output logic [1:0]                   R_STATUS,
    output logic [NUM_REQ-1:0]           GRANT,
    output logic [`ADDR_WIDTH-1:0]       TX_ADDR,
    output logic [`DATA_WIDTH-1:0]       TX_DATA,
    output logic                         TX_PEND,
    output logic                         TX_REQ,
    output logic                         TX_PRIORITY,
    input  logic                         TX_ACK,
    input  logic                         TX_SUCC,
    input  logic                         TX_FAIL,
    output logic                         TX_RESP_ACK
);

    // The counter value seen on the cycle that gives up, so a phase lasts
    // exactly ACK_TIMEOUT cycles.
    localparam logic [TMO_W-1:0] TMO_LAST = ACK_TIMEOUT - TMO_W'(1);

    arb_state_t               r_state, w_state_nxt;
    logic [1:0]               r_grant, w_grant_nxt;
    logic                     r_owner, w_owner_nxt;
    logic                     r_ptr, w_ptr_nxt;
    logic [`ADDR_WIDTH-1:0]   r_tx_addr, w_addr_nxt;
    logic [`DATA_WIDTH-1:0]   r_tx_data, w_data_nxt;
    logic                     r_tx_pend, w_pend_nxt;
    logic                     r_tx_req, w_req_nxt;
    logic                     r_tx_prio, w_prio_nxt;
    logic                     r_resp_ack, w_rack_nxt;
    logic [1:0]               r_ready, w_ready_nxt;
    logic [1:0]               r_done, w_done_nxt;
    logic [1:0]               r_status, w_status_nxt;
    logic [1:0]               r_rsp, w_rsp_nxt;
    logic [TMO_W-1:0]         r_cnt, w_cnt_nxt;

    logic [1:0]               w_pick_grant;
    logic                     w_pick_idx;
    logic                     w_tmo;

    mbus_rr_pick2 u_pick (
        .i_req   (R_VALID),
        .i_ptr   (r_ptr),
        .o_grant (w_pick_grant),
        .o_idx   (w_pick_idx)
    );

    assign w_tmo = (r_cnt == TMO_LAST);

    // Next-state and next-register logic. Every datapath register is computed
    // here so the sequential block is a plain copy. The timeout counter
    // defaults to 0, so it clears on any state change and only advances
    // while waiting in SEND, ACKLOW or RESP.
    always_comb begin
        w_state_nxt  = r_state;
        w_grant_nxt  = r_grant;
        w_owner_nxt  = r_owner;
        w_ptr_nxt    = r_ptr;
        w_addr_nxt   = r_tx_addr;
        w_data_nxt   = r_tx_data;
        w_pend_nxt   = r_tx_pend;
        w_req_nxt    = r_tx_req;
        w_prio_nxt   = r_tx_prio;
        w_rack_nxt   = r_resp_ack;
        w_ready_nxt  = 2'b00;
        w_done_nxt   = 2'b00;
        w_status_nxt = r_status;
        w_rsp_nxt    = r_rsp;
        w_cnt_nxt    = '0;

        case (r_state)
            S_IDLE: begin
                if (|R_VALID) begin
                    w_grant_nxt = w_pick_grant;
                    w_owner_nxt = w_pick_idx;
                    w_addr_nxt  = w_pick_idx ? R_ADDR[2*`ADDR_WIDTH-1:`ADDR_WIDTH]
                                             : R_ADDR[`ADDR_WIDTH-1:0];
                    w_prio_nxt  = R_PRIO[w_pick_idx];
                    w_state_nxt = S_LOAD;
                end
            end

            S_LOAD: begin
                if (R_VALID[r_owner]) begin
                    w_data_nxt  = r_owner ? R_DATA[2*`DATA_WIDTH-1:`DATA_WIDTH]
                                          : R_DATA[`DATA_WIDTH-1:0];
                    w_pend_nxt  = ~R_LAST[r_owner];
                    w_req_nxt   = 1'b1;
                    w_state_nxt = S_SEND;
                end
            end

            S_SEND, S_ACKLOW: begin
                // A bus error reported mid-transfer skips straight to the
                // response acknowledge with a fail status.
                if (TX_FAIL) begin
                    w_req_nxt   = 1'b0;
                    w_pend_nxt  = 1'b0;
                    w_rsp_nxt   = ST_FAIL;
                    w_rack_nxt  = 1'b1;
                    w_state_nxt = S_RACK;
                end else if ((r_state == S_SEND) && TX_ACK) begin
                    w_req_nxt   = 1'b0;
                    w_ready_nxt = r_grant;
                    w_state_nxt = S_ACKLOW;
                end else if ((r_state == S_ACKLOW) && !TX_ACK) begin
                    w_state_nxt = r_tx_pend ? S_LOAD : S_RESP;
                    w_pend_nxt  = 1'b0;
                    if (r_tx_pend) begin
                        w_pend_nxt = 1'b1;
                    end
                end else if (w_tmo) begin
                    w_req_nxt    = 1'b0;
                    w_pend_nxt   = 1'b0;
                    w_done_nxt   = r_grant;
                    w_status_nxt = ST_TMO;
                    w_grant_nxt  = 2'b00;
                    w_ptr_nxt    = ~r_owner;
                    w_state_nxt  = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + TMO_W'(1);
                end
            end

            S_RESP: begin
                if (TX_SUCC || TX_FAIL) begin
                    w_rsp_nxt   = TX_SUCC ? ST_SUCC : ST_FAIL;
                    w_rack_nxt  = 1'b1;
                    w_state_nxt = S_RACK;
                end else if (w_tmo) begin
                    w_done_nxt   = r_grant;
                    w_status_nxt = ST_TMO;
                    w_grant_nxt  = 2'b00;
                    w_ptr_nxt    = ~r_owner;
                    w_state_nxt  = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + TMO_W'(1);
                end
            end

            S_RACK: begin
                if (!TX_SUCC && !TX_FAIL) begin
                    w_rack_nxt   = 1'b0;
                    w_done_nxt   = r_grant;
                    w_status_nxt = r_rsp;
                    w_grant_nxt  = 2'b00;
                    w_ptr_nxt    = ~r_owner;
                    w_state_nxt  = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops TX_REQ/TX_RESP_ACK at once
    // and forgets the in-flight message without a completion pulse.
    always_ff @(posedge CLK_EXT or negedge RESETn) begin
        if (!RESETn) begin
            r_state    <= S_IDLE;
            r_grant    <= 2'b00;
            r_owner    <= 1'b0;
            r_ptr      <= 1'b0;
            r_tx_addr  <= '0;
            r_tx_data  <= '0;
            r_tx_pend  <= 1'b0;
            r_tx_req   <= 1'b0;
            r_tx_prio  <= 1'b0;
            r_resp_ack <= 1'b0;
            r_ready    <= 2'b00;
            r_done     <= 2'b00;
            r_status   <= 2'b00;
            r_rsp      <= 2'b00;
            r_cnt      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_grant    <= w_grant_nxt;
            r_owner    <= w_owner_nxt;
            r_ptr      <= w_ptr_nxt;
            r_tx_addr  <= w_addr_nxt;
            r_tx_data  <= w_data_nxt;
            r_tx_pend  <= w_pend_nxt;
            r_tx_req   <= w_req_nxt;
            r_tx_prio  <= w_prio_nxt;
            r_resp_ack <= w_rack_nxt;
            r_ready    <= w_ready_nxt;
            r_done     <= w_done_nxt;
            r_status   <= w_status_nxt;
            r_rsp      <= w_rsp_nxt;
            r_cnt      <= w_cnt_nxt;
        end
    end

    assign R_READY     = r_ready;
    assign R_DONE      = r_done;
    assign R_STATUS    = r_status;
    assign GRANT       = r_grant;
    assign TX_ADDR     = r_tx_addr;
    assign TX_DATA     = r_tx_data;
    assign TX_PEND     = r_tx_pend;
    assign TX_REQ      = r_tx_req;
    assign TX_PRIORITY = r_tx_prio;
    assign TX_RESP_ACK = r_resp_ack;

endmodule

// File: doc/mbus_tx_arbiter.md
Name: mbus_tx_arbiter

Overview:
Shares the single MBus node transmit port (TX_ADDR/TX_DATA/TX_PEND/TX_REQ/TX_PRIORITY/TX_ACK/TX_SUCC/TX_FAIL/TX_RESP_ACK) between two requesters: the ICE host command path (requester 0) and the on-board event generator (requester 1).
- Grants the port per message, round-robin, and locks the grant until the message completes.
- Sequences the node's word-by-word REQ/ACK handshake.
- Performs the response handshake.
- Returns a per-requester completion status.
- Sits between the requesters and the general layer wrapper, in the CLK_EXT domain, and consumes the wrapper's double-synchronised TX_ACK.

Parameters:
NUM_REQ, 2, number of requesters; fixed at 2 in this revision, kept for package constants.
ACK_TIMEOUT, 20'hFFFFF, CLK_EXT cycles allowed per handshake phase before the arbiter gives up on the node.

Ports:
CLK_EXT  in  1  system clock
RESETn  in  1  asynchronous active-low reset
R_VALID  in  2  per requester: word presented
R_ADDR  in  2x`ADDR_WIDTH  per requester destination address; sampled with the first word only
R_DATA  in  2x`DATA_WIDTH  per requester data word
R_LAST  in  2  per requester: current word is the final word of the message
R_PRIO  in  2  per requester priority request; sampled with the first word
R_READY  out  2  one-cycle pulse: word consumed by the node
R_DONE  out  2  one-cycle pulse: message finished
R_STATUS  out  2  per requester, valid with R_DONE: 2'b01 succ, 2'b10 fail, 2'b11 timeout
GRANT  out  2  one-hot current owner; 0 when idle
TX_ADDR  out  `ADDR_WIDTH  to node
TX_DATA  out  `DATA_WIDTH  to node
TX_PEND  out  1  to node: more words follow
TX_REQ  out  1  to node
TX_PRIORITY  out  1  to node
TX_ACK  in  1  from node (already synchronised)
TX_SUCC  in  1  from node
TX_FAIL  in  1  from node
TX_RESP_ACK  out  1  to node

Behaviour:
- Reset: all outputs 0, state IDLE, round-robin pointer favours requester 0. Reset mid-message drops TX_REQ and TX_RESP_ACK immediately. No R_DONE is issued for the aborted message.
- IDLE: when any R_VALID is set, pick the owner.
  - Single request: that requester wins.
  - Both requesting: the requester not served last wins.
  - Latch owner into GRANT, R_ADDR into TX_ADDR, R_PRIO into TX_PRIORITY. Go to LOAD the same cycle (1-cycle arbitration latency).
- LOAD: wait for R_VALID[owner].
  - Register R_DATA into TX_DATA and ~R_LAST into TX_PEND.
  - Go to SEND.
  - Other requesters' R_VALID are ignored while a grant is held.
- SEND: TX_REQ=1. On TX_ACK=1:
  - TX_REQ=0 next cycle.
  - Pulse R_READY[owner] for 1 cycle.
  - Go to ACKLOW.
- ACKLOW: wait for TX_ACK=0.
  - If the word just sent had TX_PEND=1, go to LOAD.
  - Otherwise clear TX_PEND and go to RESP.
  - TX_REQ must never rise while TX_ACK is still 1.
- RESP: wait for TX_SUCC or TX_FAIL.
  - Record status: SUCC takes precedence if both are seen in the same cycle.
  - Go to RACK.
- RACK: TX_RESP_ACK=1 until TX_SUCC=0 and TX_FAIL=0. Then TX_RESP_ACK=0, pulse R_DONE[owner] with R_STATUS, update the round-robin pointer, clear GRANT, go to IDLE.
- Timeout: a 20-bit counter clears on every state change and counts in SEND, ACKLOW and RESP.
  - On reaching ACK_TIMEOUT: drop TX_REQ/TX_PEND, report status 2'b11 via R_DONE, go to IDLE.
  - LOAD is never timed: the requester may stall indefinitely while TX_PEND stays high.
- TX_SUCC/TX_FAIL asserted outside RESP are ignored; the node can raise them early on a bus error. In SEND or ACKLOW an asserted TX_FAIL jumps directly to RACK with status fail.
- Single-word message (R_LAST=1 on the first word): TX_PEND is 0 for the whole transfer.
- R_STATUS holds its last value between R_DONE pulses.

Decomposition:
- Shared package / include (mbus_def): state encoding constants, status codes (ST_SUCC, ST_FAIL, ST_TMO), NUM_REQ. Existing `ADDR_WIDTH/`DATA_WIDTH are used as-is.
- One natural sub-module: mbus_rr_pick2 (combinational round-robin picker, with the pointer register held in the parent).
- FSM, timeout counter and TX registers stay in mbus_tx_arbiter.

Test Plan:
- R0 sends one word (addr 0x12, data 0xDEADBEEF, LAST=1):
  - TX_PEND=0, TX_REQ rises 1 cycle after GRANT=01.
  - Node SUCC -> TX_RESP_ACK high until SUCC falls.
  - R_DONE[0] with status 01.
- R1 sends 3 words 0x1,0x2,0x3:
  - TX_PEND=1,1,0 on successive words.
  - Three R_READY[1] pulses.
  - TX_REQ never high while TX_ACK high.
- R0 and R1 both assert VALID in the same cycle from reset:
  - R0 is granted first, then R1.
  - A second simultaneous request is granted R0 first again (alternation holds).
- Node returns TX_FAIL during ACKLOW of word 2 of 4 -> RACK entered, R_DONE status 10, remaining words never read.
- TX_ACK held low with ACK_TIMEOUT=16 -> exactly 16 cycles in SEND, then TX_REQ=0, status 11, GRANT=0.
- RESETn pulsed low mid-SEND -> TX_REQ=0 asynchronously, no R_DONE; the next request is arbitrated normally.
